// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared types for regfile_arbiter.
//   state_t - access sequencer states (IDLE -> ACCESS -> RESP)
//   req_t   - request latched at accept time
//   DATA_W_DEF / ADDR_W_DEF - default widths, matching register_file_3
package regfile_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  we;
        logic                  re1;
        logic                  re2;
        logic [ADDR_W_DEF-1:0] rs1;
        logic [ADDR_W_DEF-1:0] rs2;
        logic [ADDR_W_DEF-1:0] rd;
        logic [DATA_W_DEF-1:0] wdata;
        logic                  id;
    } req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: grant logic for two requesters.
//   clk, rst_n : clock, synchronous active-low reset
//   valid      : per-requester request valid
//   advance    : a grant was accepted this cycle
//   grant      : one-hot winner, zero when nothing is valid
// Macro REGFILE_ARB_RR_EN selects round-robin (pointer register built);
// otherwise requester 0 has fixed priority and no state exists.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

`ifdef REGFILE_ARB_RR_EN
    // ptr names the requester that wins a tie.
    logic ptr;

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr <= 1'b0;
        else if (advance)
            ptr <= ~grant[1];   // hand the tie to whoever just lost
    end

    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = ptr ? 2'b10 : 2'b01;
    end
`else
    always_comb begin
        grant = valid;
        if (valid[0])
            grant = 2'b01;
    end

    // Pointer not built in fixed-priority mode.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst_n, advance};
`endif

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: shares the write port and two read ports of the 32x16
// SIMD register file between two requesters.
//   clk, rst_n              : clock, synchronous active-low reset
//   req_*                   : per-requester valid/ready request channel,
//                             requester i fields at [i*W +: W]
//   rsp_*                   : registered response (valid/ready), id + read data
//   rf_*                    : register file control, active only in ACCESS
// Macro REGFILE_ARB_RR_EN: round-robin instead of fixed priority.
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREQ   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ-1:0]        req_re1,
    input  logic [NREQ-1:0]        req_re2,
    input  logic [NREQ*ADDR_W-1:0] req_rs1,
    input  logic [NREQ*ADDR_W-1:0] req_rs2,
    input  logic [NREQ*ADDR_W-1:0] req_rd,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [DATA_W-1:0]      rsp_rs1_data,
    output logic [DATA_W-1:0]      rsp_rs2_data,
    output logic [ADDR_W-1:0]      rf_rs1,
    output logic [ADDR_W-1:0]      rf_rs2,
    output logic [ADDR_W-1:0]      rf_rd,
    output logic [DATA_W-1:0]      rf_wr_data,
    output logic                   rf_rd_wr_en,
    output logic                   rf_rs1_rd_en,
    output logic                   rf_rs2_rd_en,
    input  logic [DATA_W-1:0]      rf_rs1_data,
    input  logic [DATA_W-1:0]      rf_rs2_data
);

    state_t          state, state_nxt;
    req_t            lat, win;
    logic [NREQ-1:0] grant;
    logic            fire;
    logic            acc;
    logic            sel;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (req_valid),
        .advance (fire),
        .grant   (grant)
    );

    // Offer a grant only when idle; rst_n gating keeps everything quiet
    // through a reset cycle.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign fire      = |(req_valid & req_ready);
    assign sel       = grant[1];

    always_comb begin
        win.id    = sel;
        win.we    = sel ? req_we[1]  : req_we[0];
        win.re1   = sel ? req_re1[1] : req_re1[0];
        win.re2   = sel ? req_re2[1] : req_re2[0];
        win.rs1   = sel ? req_rs1[ADDR_W +: ADDR_W]   : req_rs1[0 +: ADDR_W];
        win.rs2   = sel ? req_rs2[ADDR_W +: ADDR_W]   : req_rs2[0 +: ADDR_W];
        win.rd    = sel ? req_rd[ADDR_W +: ADDR_W]    : req_rd[0 +: ADDR_W];
        win.wdata = sel ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fire) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat          <= '0;
            rsp_id       <= 1'b0;
            rsp_rs1_data <= '0;
            rsp_rs2_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && fire)
                lat <= win;
            // Regfile reads are combinational, so the data seen here is the
            // pre-write value even when this request also writes.
            if (state == ACCESS) begin
                rsp_id       <= lat.id;
                rsp_rs1_data <= lat.re1 ? rf_rs1_data : '0;
                rsp_rs2_data <= lat.re2 ? rf_rs2_data : '0;
            end
        end
    end

    // Gated by rst_n so a write sitting in ACCESS is never issued on the
    // reset edge.
    assign acc          = rst_n && (state == ACCESS);
    assign rsp_valid    = rst_n && (state == RESP);
    assign rf_rs1       = acc ? lat.rs1 : '0;
    assign rf_rs2       = acc ? lat.rs2 : '0;
    assign rf_rd        = acc ? lat.rd  : '0;
    assign rf_wr_data   = acc ? lat.wdata : '0;
    assign rf_rs1_rd_en = acc && lat.re1;
    assign rf_rs2_rd_en = acc && lat.re2;
    // The regfile does not protect x0, so x0 writes are dropped here.
    assign rf_rd_wr_en  = acc && lat.we && (lat.rd != '0);

endmodule

// File: tb/tb_regfile_arbiter.sv
module tb_regfile_arbiter;

    localparam int DW = 16;
    localparam int AW = 5;
`ifdef REGFILE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready, req_we, req_re1, req_re2;
    logic [2*AW-1:0] req_rs1, req_rs2, req_rd;
    logic [2*DW-1:0] req_wdata;
    logic            rsp_valid, rsp_ready, rsp_id;
    logic [DW-1:0]   rsp_rs1_data, rsp_rs2_data;
    logic [AW-1:0]   rf_rs1, rf_rs2, rf_rd;
    logic [DW-1:0]   rf_wr_data, rf_rs1_data, rf_rs2_data;
    logic            rf_rd_wr_en, rf_rs1_rd_en, rf_rs2_rd_en;

    always #5 clk = ~clk;

    regfile_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_re1(req_re1), .req_re2(req_re2),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
        .rf_wr_data(rf_wr_data), .rf_rd_wr_en(rf_rd_wr_en),
        .rf_rs1_rd_en(rf_rs1_rd_en), .rf_rs2_rd_en(rf_rs2_rd_en),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data)
    );

    // Stand-in register file: no x0 protection, combinational reads.
    logic [DW-1:0] mem [32] = '{default: '0};
    always @(posedge clk)
        if (rf_rd_wr_en) mem[rf_rd] <= rf_wr_data;
    assign rf_rs1_data = mem[rf_rs1];
    assign rf_rs2_data = mem[rf_rs2];

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural register contents plus the request in
    // flight, with m_stage = cycles since accept (0 none, 1 regfile access,
    // 2 response offered).
    logic [DW-1:0] mdl_rf [32] = '{default: '0};
    int            m_stage = 0;
    bit            pref = 0;       // requester favoured on a tie (RR only)
    int            acc_cnt = 0, rsp_cnt = 0, wr_pulses = 0;
    bit            e_id, e_we, e_re1, e_re2;
    logic [AW-1:0] e_rs1, e_rs2, e_rd;
    logic [DW-1:0] e_wd, e_d1, e_d2, last_d1;
    int            obs[$];

    task automatic step();
        int w;
        logic [1:0] er;
        bit ac;
        @(negedge clk);
        w  = (req_valid == 2'b10 || (req_valid == 2'b11 && RR && pref)) ? 1 : 0;
        er = (!rst_n || m_stage != 0 || req_valid == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
        ac = rst_n && m_stage == 1;
        chk("req_ready", req_ready, er);
        chk("rsp_valid", rsp_valid, rst_n && m_stage == 2);
        if (rst_n && m_stage == 2) begin
            chk("rsp_id", rsp_id, e_id);
            chk("rsp_d1", rsp_rs1_data, e_d1);
            chk("rsp_d2", rsp_rs2_data, e_d2);
        end
        chk("rf_en", {rf_rd_wr_en, rf_rs1_rd_en, rf_rs2_rd_en},
            {ac && e_we && e_rd != 0, ac && e_re1, ac && e_re2});
        if (ac)
            chk("rf_addr", {rf_rs1, rf_rs2, rf_rd, rf_wr_data}, {e_rs1, e_rs2, e_rd, e_wd});
        else
            chk("rf_quiet", {rf_rs1, rf_rs2, rf_rd, rf_wr_data}, '0);
        if (rf_rd_wr_en) wr_pulses++;
        if (|(req_valid & req_ready)) obs.push_back(int'(req_ready[1]));
        if (rsp_valid && rsp_ready) begin
            rsp_cnt++;
            last_d1 = rsp_rs1_data;
        end
        if (!rst_n) begin
            m_stage = 0;
            pref    = 0;
        end else if (m_stage == 0) begin
            if (er != 2'b00) begin
                e_id  = w[0];
                e_we  = req_we[w];  e_re1 = req_re1[w];  e_re2 = req_re2[w];
                e_rs1 = req_rs1[w*AW +: AW];
                e_rs2 = req_rs2[w*AW +: AW];
                e_rd  = req_rd[w*AW +: AW];
                e_wd  = req_wdata[w*DW +: DW];
                e_d1  = e_re1 ? mdl_rf[e_rs1] : '0;
                e_d2  = e_re2 ? mdl_rf[e_rs2] : '0;
                pref  = (w == 0);
                m_stage = 1;
                acc_cnt++;
            end
        end else if (m_stage == 1) begin
            if (e_we && e_rd != 0) mdl_rf[e_rd] = e_wd;
            m_stage = 2;
        end else if (rsp_ready) begin
            m_stage = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input bit we, input bit re1, input bit re2,
                           input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [AW-1:0] rd, input logic [DW-1:0] wd);
        req_valid[id] = 1'b1;
        req_we[id]    = we;
        req_re1[id]   = re1;
        req_re2[id]   = re2;
        req_rs1[id*AW +: AW]   = rs1;
        req_rs2[id*AW +: AW]   = rs2;
        req_rd[id*AW +: AW]    = rd;
        req_wdata[id*DW +: DW] = wd;
    endtask

    task automatic wait_accept();
        int n;
        n = acc_cnt;
        for (int i = 0; i < 20 && acc_cnt == n; i++) step();
        chk("accept_timeout", acc_cnt, n + 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_stage != 0; i++) step();
        chk("drain_timeout", m_stage, 0);
    endtask

    task automatic do_req(input int id, input bit we, input bit re1, input bit re2,
                          input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                          input logic [AW-1:0] rd, input logic [DW-1:0] wd);
        set_req(id, we, re1, re2, rs1, rs2, rd, wd);
        wait_accept();
        req_valid = '0;
        drain();
    endtask

    initial begin
        int p, r;
        logic [DW-1:0] held;
        rst_n = 1'b0; req_valid = '0; req_we = '0; req_re1 = '0; req_re2 = '0;
        req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_wdata = '0; rsp_ready = 1'b1;
        @(posedge clk); #1;

        // reset: outputs quiet even with requests pending
        step();
        req_valid = 2'b11;
        step();
        chk("rst_rsp", {rsp_id, rsp_rs1_data, rsp_rs2_data}, '0);
        req_valid = '0;
        rst_n = 1'b1;

        // write x5 then read it back
        p = wr_pulses;
        do_req(0, 1, 0, 0, 0, 0, 5, 16'hA5A5);
        chk("x5_wr_pulse", wr_pulses - p, 1);
        do_req(0, 0, 1, 0, 5, 0, 0, 0);
        chk("x5_rd", last_d1, 16'hA5A5);

        // x0 write is suppressed and x0 reads as zero
        p = wr_pulses;
        do_req(1, 1, 0, 0, 0, 0, 0, 16'hFFFF);
        do_req(1, 0, 1, 0, 0, 0, 0, 0);
        chk("x0_no_wr", wr_pulses - p, 0);
        chk("x0_rd", last_d1, 16'h0000);

        // back-pressure: hold the response while both requesters wait
        rsp_ready = 1'b0;
        set_req(1, 0, 1, 1, 5, 0, 0, 0);
        wait_accept();
        set_req(0, 0, 1, 0, 5, 0, 0, 0);
        step();
        held = rsp_rs1_data;
        chk("stall_data", held, 16'hA5A5);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_hold", rsp_rs1_data, held);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        step();
        step();
        chk("stall_idle", m_stage, 0);

        // reset during the ACCESS cycle of a write to x7
        set_req(0, 1, 0, 0, 0, 0, 7, 16'h1234);
        wait_accept();
        p = wr_pulses; r = rsp_cnt;
        rst_n = 1'b0;
        req_valid = '0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("rst_x7", mem[7], 16'h0000);
        chk("rst_no_wr", wr_pulses - p, 0);
        chk("rst_no_rsp", rsp_cnt - r, 0);

        // continuous contention straight after reset
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        obs.delete();
        set_req(0, 0, 1, 0, 5, 0, 0, 0);
        set_req(1, 0, 0, 1, 0, 5, 0, 0);
        for (int i = 0; i < 12; i++) step();
        req_valid = '0;
        drain();
        chk("cont_cnt", obs.size() >= 3, 1);
        if (obs.size() >= 3) begin
            chk("cont_g0", obs[0], 0);
            chk("cont_g1", obs[1], RR ? 1 : 0);
            chk("cont_g2", obs[2], 0);
        end

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            req_valid = 2'($urandom_range(0, 3));
            req_we    = 2'($urandom_range(0, 3));
            req_re1   = 2'($urandom_range(0, 3));
            req_re2   = 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                req_rs1[k*AW +: AW]   = AW'($urandom_range(0, 7));
                req_rs2[k*AW +: AW]   = AW'($urandom_range(0, 7));
                req_rd[k*AW +: AW]    = AW'($urandom_range(0, 7));
                req_wdata[k*DW +: DW] = DW'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        drain();
        for (int k = 0; k < 8; k++)
            chk("final_rf", mem[k], mdl_rf[k]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
